gate_sweep_ctrl: RTL and testbench



---
 rtl/gate_sweep_pkg.sv | 8 +
 rtl/next_op_find.sv | 20 ++
 rtl/gate_sweep_ctrl.sv | 93 +++++++++
 tb/tb_gate_sweep_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: opcodes, golden truth tables and FSM states shared by the gate sweep sequencer.
package gate_sweep_pkg;
   localparam int NUM_OPS = 7;
   typedef enum logic [2:0] {OP_AND, OP_OR, OP_NOT, OP_NAND, OP_NOR, OP_XOR, OP_XNOR} gate_op_e;
   // bit i of each entry is the expected Y for {A,B} = i
   localparam logic [3:0] GOLDEN [NUM_OPS] = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001};
   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_EMIT, S_DONE} state_e;
endpackage

// File: rtl/next_op_find.sv
// next_op_find: lowest enabled opcode above cur_i (or the lowest overall when first_i is set).
module next_op_find
   import gate_sweep_pkg::*;
(
   input  logic [NUM_OPS-1:0] mask_i,
   input  logic [2:0]         cur_i,
   input  logic               first_i,
   output logic [2:0]         nxt_o,
   output logic               found_o
);
   always_comb begin
      nxt_o = '0;
      found_o = 1'b0;
      for (int i = NUM_OPS - 1; i >= 0; i--)
         if (mask_i[i] && (first_i || 3'(i) > cur_i)) begin
            nxt_o = 3'(i);
            found_o = 1'b1;
         end
   end
endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: walks enabled gate opcodes through all four input vectors and checks each truth table.
module gate_sweep_ctrl
   import gate_sweep_pkg::*;
#(
   parameter int SETTLE = 1,
   parameter int OPW    = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [NUM_OPS-1:0] op_mask,
   output logic               A,
   output logic               B,
   output logic [OPW-1:0]     OP,
   input  logic               Y,
   output logic               busy,
   output logic               tt_valid,
   output logic [OPW-1:0]     tt_op,
   output logic [3:0]         tt_data,
   output logic               tt_err,
   output logic [NUM_OPS-1:0] fail_mask,
   output logic               done,
   output logic               pass
);
   state_e state_q, state_d;
   logic [NUM_OPS-1:0] mask_q, fail_q;
   logic [2:0] op_q, tt_op_q, nxt;
   logic [1:0] vec_q;
   logic [3:0] cnt_q, tt_q;
   logic [2:0] sh_q;
   logic found, accept, smp, last, err;
   assign accept = state_q == S_IDLE && start;
   assign smp = state_q == S_APPLY && cnt_q == 4'(SETTLE);
   assign last = smp && vec_q == 2'd3;
   assign err = tt_q != GOLDEN[tt_op_q];
   // in IDLE the search runs on the live op_mask so the first opcode is known at the start edge
   next_op_find u_find (
      .mask_i (state_q == S_IDLE ? op_mask : mask_q),
      .cur_i  (op_q),
      .first_i(state_q == S_IDLE),
      .nxt_o  (nxt),
      .found_o(found)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= S_IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q == S_IDLE  ? (start ? (found ? S_APPLY : S_DONE) : S_IDLE)
              : state_q == S_APPLY ? (last ? S_EMIT : S_APPLY)
              : state_q == S_EMIT  ? (found ? S_APPLY : S_DONE)
              : S_IDLE;
   end
   always_comb begin
      busy = state_q == S_APPLY || state_q == S_EMIT;
      A = busy & vec_q[1];
      B = busy & vec_q[0];
      OP = busy ? OPW'(op_q) : '0;
      tt_valid = state_q == S_EMIT;
      tt_op = OPW'(tt_op_q);
      tt_data = tt_q;
      tt_err = tt_valid && err;
      fail_mask = fail_q;
      done = state_q == S_DONE;
      pass = done && fail_q == '0;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         mask_q <= '0;
         fail_q <= '0;
         op_q <= '0;
         tt_op_q <= '0;
         vec_q <= '0;
         cnt_q <= '0;
         sh_q <= '0;
         tt_q <= '0;
      end else begin
         if (accept) begin
            mask_q <= op_mask;
            fail_q <= '0;
         end
         if ((accept || state_q == S_EMIT) && found) op_q <= nxt;
         cnt_q <= (smp || state_q != S_APPLY) ? 4'd0 : cnt_q + 4'd1;
         if (smp) begin
            vec_q <= vec_q + 2'd1;
            sh_q <= {Y, sh_q[2:1]};
         end
         if (last) begin
            tt_q <= {Y, sh_q};
            tt_op_q <= op_q;
         end
         if (state_q == S_EMIT && err) fail_q[tt_op_q] <= 1'b1;
      end
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: directed checks of the sweep sequencer against a behavioural gate unit.
module tb_gate_sweep_ctrl;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, stuck = 1'b0;
   logic [6:0] op_mask = '0;
   logic A1, B1, Y1, busy1, ttv1, tte1, done1, pass1;
   logic A0, B0, Y0, busy0, ttv0, tte0, done0, pass0;
   logic [2:0] OP1, OP0, tto1, tto0;
   logic [3:0] ttd1, ttd0;
   logic [6:0] fm1, fm0;
   int tests = 0, fails = 0;
   logic [3:0] exp_tt [7] = '{4'h8, 4'hE, 4'h3, 4'h7, 4'h1, 4'h6, 4'h9};
   always #5 clk = ~clk;
   function automatic logic gm(input logic a, input logic b, input logic [2:0] op, input logic stk);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return ~a;
         3'd3: return ~(a & b);
         3'd4: return ~(a | b);
         3'd5: return stk ? 1'b0 : a ^ b;
         3'd6: return ~(a ^ b);
         default: return 1'b0;
      endcase
   endfunction
   assign Y1 = gm(A1, B1, OP1, stuck);
   assign Y0 = gm(A0, B0, OP0, stuck);
   gate_sweep_ctrl #(.SETTLE(1), .OPW(3)) dut1 (
      .clk(clk), .rst(rst), .start(start), .op_mask(op_mask), .A(A1), .B(B1), .OP(OP1), .Y(Y1),
      .busy(busy1), .tt_valid(ttv1), .tt_op(tto1), .tt_data(ttd1), .tt_err(tte1),
      .fail_mask(fm1), .done(done1), .pass(pass1));
   gate_sweep_ctrl #(.SETTLE(0), .OPW(3)) dut0 (
      .clk(clk), .rst(rst), .start(start), .op_mask(op_mask), .A(A0), .B(B0), .OP(OP0), .Y(Y0),
      .busy(busy0), .tt_valid(ttv0), .tt_op(tto0), .tt_data(ttd0), .tt_err(tte0),
      .fail_mask(fm0), .done(done0), .pass(pass0));
   // leaves the caller at the first falling edge after the accepted start edge (n = 0)
   task automatic pulse_start(input logic [6:0] m);
      @(negedge clk);
      op_mask = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic test_reset();
      #2 rst = 1'b1;
      #3;
      tests++;
      if ({busy1, A1, B1, OP1, ttv1, tto1, ttd1, tte1, fm1, done1, pass1} !== '0) begin
         fails++;
         $display("FAIL reset_outputs_s1: got busy=%b op=%0h tt=%0h fm=%0h done=%b want all 0", busy1, OP1, ttd1, fm1, done1);
      end
      tests++;
      if ({busy0, A0, B0, OP0, ttv0, tto0, ttd0, tte0, fm0, done0, pass0} !== '0) begin
         fails++;
         $display("FAIL reset_outputs_s0: got busy=%b op=%0h tt=%0h fm=%0h done=%b want all 0", busy0, OP0, ttd0, fm0, done0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic test_reset_mid();
      int nstr = 0, done_at = -1;
      pulse_start(7'h7F);
      repeat (30) @(negedge clk);
      tests++;
      if ({OP1, A1, B1} !== {3'd3, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL mid_apply_op3: got OP=%0d A=%b B=%b want OP=3 A=0 B=1", OP1, A1, B1);
      end
      rst = 1'b1;
      #1;
      tests++;
      if ({busy1, A1, B1, OP1, ttv1, fm1} !== '0) begin
         fails++;
         $display("FAIL reset_mid_sweep: got busy=%b A=%b B=%b OP=%0d ttv=%b fm=%0h want all 0", busy1, A1, B1, OP1, ttv1, fm1);
      end
      @(negedge clk);
      rst = 1'b0;
      pulse_start(7'h7F);
      for (int n = 0; n < 70; n++) begin
         if (ttv1) nstr++;
         if (done1 && done_at < 0) done_at = n;
         @(negedge clk);
      end
      tests++;
      if (nstr !== 7 || done_at !== 63) begin
         fails++;
         $display("FAIL sweep_after_reset: got strobes=%0d done_at=%0d want 7 and 63", nstr, done_at);
      end
   endtask
   task automatic test_full();
      int nstr = 0, done_at = -1, ndone = 0, bad_busy = 0, nerr = 0;
      logic [2:0] ops [$];
      logic [3:0] dat [$];
      logic pass_at = 1'b0;
      pulse_start(7'h7F);
      for (int n = 0; n < 70; n++) begin
         if (ttv1) begin
            nstr++;
            ops.push_back(tto1);
            dat.push_back(ttd1);
            if (tte1) nerr++;
         end
         if (done1) begin
            ndone++;
            if (done_at < 0) begin
               done_at = n;
               pass_at = pass1;
            end
         end
         if (busy1 !== (n < 63)) bad_busy++;
         @(negedge clk);
      end
      tests++;
      if (nstr !== 7) begin
         fails++;
         $display("FAIL full_strobes: got %0d want 7", nstr);
      end
      for (int k = 0; k < 7 && k < nstr; k++) begin
         tests++;
         if (ops[k] !== 3'(k) || dat[k] !== exp_tt[k]) begin
            fails++;
            $display("FAIL full_table_%0d: got op=%0d data=%b want op=%0d data=%b", k, ops[k], dat[k], k, exp_tt[k]);
         end
      end
      tests++;
      if (nerr !== 0) begin
         fails++;
         $display("FAIL full_tt_err: got %0d errors want 0", nerr);
      end
      tests++;
      if (done_at !== 63 || ndone !== 1 || pass_at !== 1'b1) begin
         fails++;
         $display("FAIL full_done: got done_at=%0d pulses=%0d pass=%b want 63 1 1", done_at, ndone, pass_at);
      end
      tests++;
      if (bad_busy !== 0) begin
         fails++;
         $display("FAIL full_busy: got %0d bad cycles want 0", bad_busy);
      end
   endtask
   task automatic test_fault();
      int nstr = 0, done_at = -1;
      logic [2:0] op = '0;
      logic [3:0] dat = 4'hF;
      logic err = 1'b0, pass_at = 1'b1;
      logic [6:0] fm_at = '0;
      stuck = 1'b1;
      pulse_start(7'h20);
      for (int n = 0; n < 14; n++) begin
         if (ttv1) begin
            nstr++;
            op = tto1;
            dat = ttd1;
            err = tte1;
         end
         if (done1 && done_at < 0) begin
            done_at = n;
            pass_at = pass1;
            fm_at = fm1;
         end
         @(negedge clk);
      end
      stuck = 1'b0;
      tests++;
      if (nstr !== 1 || op !== 3'd5 || dat !== 4'b0000 || err !== 1'b1) begin
         fails++;
         $display("FAIL fault_strobe: got n=%0d op=%0d data=%b err=%b want 1 5 0000 1", nstr, op, dat, err);
      end
      tests++;
      if (fm_at !== 7'h20 || pass_at !== 1'b0 || done_at !== 9) begin
         fails++;
         $display("FAIL fault_summary: got fm=%0h pass=%b done_at=%0d want 20 0 9", fm_at, pass_at, done_at);
      end
   endtask
   task automatic test_sparse();
      int nstr = 0, done_at = -1, bad_op = 0;
      logic [2:0] ops [$];
      pulse_start(7'b1000101);
      for (int n = 0; n < 32; n++) begin
         if (ttv1) begin
            nstr++;
            ops.push_back(tto1);
         end
         if (OP1 inside {3'd1, 3'd3, 3'd4, 3'd5, 3'd7}) bad_op++;
         if (done1 && done_at < 0) done_at = n;
         @(negedge clk);
      end
      tests++;
      if (nstr !== 3 || ops[0] !== 3'd0 || ops[1] !== 3'd2 || ops[2] !== 3'd6) begin
         fails++;
         $display("FAIL sparse_order: got n=%0d first ops=%0d,%0d,%0d want 3 strobes 0,2,6", nstr, ops[0], ops[1], ops[2]);
      end
      tests++;
      if (bad_op !== 0 || done_at !== 27) begin
         fails++;
         $display("FAIL sparse_ops: got bad_op=%0d done_at=%0d want 0 27", bad_op, done_at);
      end
   endtask
   task automatic test_zero();
      int ndone = 0, nbusy = 0, nstr = 0;
      logic d0 = 1'b0, p0 = 1'b0;
      pulse_start(7'h00);
      d0 = done1;
      p0 = pass1;
      for (int n = 0; n < 4; n++) begin
         if (done1) ndone++;
         if (busy1) nbusy++;
         if (ttv1) nstr++;
         @(negedge clk);
      end
      tests++;
      if (d0 !== 1'b1 || p0 !== 1'b1 || ndone !== 1) begin
         fails++;
         $display("FAIL zero_done: got done=%b pass=%b pulses=%0d want 1 1 1", d0, p0, ndone);
      end
      tests++;
      if (nbusy !== 0 || nstr !== 0) begin
         fails++;
         $display("FAIL zero_idle: got busy_cycles=%0d strobes=%0d want 0 0", nbusy, nstr);
      end
   endtask
   task automatic test_back_to_back();
      int nstr = 0, done_at = -1, ndone = 0, late_busy = 0, bad_ord = 0;
      logic pass_at = 1'b0;
      pulse_start(7'h7F);
      for (int n = 0; n < 42; n++) begin
         if (ttv0) begin
            if (tto0 !== 3'(nstr) || ttd0 !== exp_tt[nstr % 7]) bad_ord++;
            nstr++;
         end
         if (done0) begin
            ndone++;
            if (done_at < 0) begin
               done_at = n;
               pass_at = pass0;
            end
         end
         if (n > 35 && busy0) late_busy++;
         if (n == 10) begin
            op_mask = 7'h01;
            start = 1'b1;
         end
         if (n == 35) start = 1'b1;
         if (n == 11 || n == 36) start = 1'b0;
         @(negedge clk);
      end
      tests++;
      if (nstr !== 7 || bad_ord !== 0) begin
         fails++;
         $display("FAIL b2b_strobes: got n=%0d misordered=%0d want 7 0", nstr, bad_ord);
      end
      tests++;
      if (done_at !== 35 || ndone !== 1 || pass_at !== 1'b1 || late_busy !== 0) begin
         fails++;
         $display("FAIL b2b_done: got done_at=%0d pulses=%0d pass=%b late_busy=%0d want 35 1 1 0", done_at, ndone, pass_at, late_busy);
      end
      repeat (40) @(negedge clk);
   endtask
   initial begin
      test_reset();
      test_full();
      test_fault();
      test_reset_mid();
      test_sparse();
      test_zero();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
